// File: rtl/sda_kernel_ctrl_reg_multi_if.sv
// Host register bus for the kernel control block: request held until a
// single-cycle acknowledge; read data travels with the acknowledge.
interface sda_kernel_ctrl_reg_multi_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  reg_req;
   logic                  reg_ack;
   logic                  reg_write_en;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [31:0]           reg_wdata;
   logic [3:0]            reg_wstrb;
   logic [31:0]           reg_rdata;

   modport master (
      output reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
      input  reg_ack, reg_rdata
   );

   modport slave (
      input  reg_req, reg_write_en, reg_addr, reg_wdata, reg_wstrb,
      output reg_ack, reg_rdata
   );
endinterface

// File: rtl/sda_kernel_ctrl_reg_multi.sv
// Kernel control register block: host CTRL/GIE/IER/ISR/CHAN_MASK registers that
// launch a set of action channels over four-phase go/done handshakes.
module sda_kernel_ctrl_reg_multi #(
   parameter int ADDR_WIDTH  = 12,
   parameter int NUM_ACTIONS = 2,
   parameter int REG_BASE    = 0
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   sda_kernel_ctrl_reg_multi_if.slave   reg_bus,
   output logic [NUM_ACTIONS-1:0]       go_r,
   input  logic [NUM_ACTIONS-1:0]       go_a,
   input  logic [NUM_ACTIONS-1:0]       done_r,
   output logic [NUM_ACTIONS-1:0]       done_a,
   output logic                         interrupt
);

   localparam int WW = ADDR_WIDTH - 2;

   typedef enum logic [2:0] {
      CH_IDLE,
      CH_GO_REQ,
      CH_GO_REL,
      CH_RUN,
      CH_DONE_ACK
   } ch_state_t;

   ch_state_t              ch_state [NUM_ACTIONS];
   logic                   req_seen;
   logic                   running;
   logic                   ap_done;
   logic                   ap_ready;
   logic                   auto_restart;
   logic                   gie;
   logic [1:0]             ier;
   logic [1:0]             isr;
   logic [NUM_ACTIONS-1:0] chan_mask;

   logic [WW-1:0] word_idx;
   logic          in_window;
   logic          access;
   logic          wr_en;
   logic          rd_en;
   logic          sel_ctrl, sel_gie, sel_ier, sel_isr, sel_mask;
   logic          byte0_wr;
   logic          all_idle;
   logic          completion;
   logic          host_start;
   logic          launch;
   logic [31:0]   ctrl_val;
   logic [31:0]   rd_mux;
   logic          unused_bits;

   // Word index relative to the window; addresses below REG_BASE wrap high and miss.
   assign word_idx  = reg_bus.reg_addr[ADDR_WIDTH-1:2] - WW'(REG_BASE >> 2);
   assign in_window = (word_idx <= WW'(4));
   assign sel_ctrl  = (word_idx == WW'(0));
   assign sel_gie   = (word_idx == WW'(1));
   assign sel_ier   = (word_idx == WW'(2));
   assign sel_isr   = (word_idx == WW'(3));
   assign sel_mask  = (word_idx == WW'(4));

   assign access   = reg_bus.reg_req & ~req_seen;
   assign wr_en    = access & in_window & reg_bus.reg_write_en;
   assign rd_en    = access & in_window & ~reg_bus.reg_write_en;
   assign byte0_wr = wr_en & reg_bus.reg_wstrb[0];

   assign completion = running & all_idle;
   assign host_start = byte0_wr & sel_ctrl & reg_bus.reg_wdata[0] & ~running;
   assign launch     = host_start | (completion & auto_restart);

   assign ctrl_val = {24'd0, auto_restart, 3'd0, ap_ready, ~running, ap_done, running};

   assign unused_bits = &{1'b0, reg_bus.reg_wdata, reg_bus.reg_wstrb, reg_bus.reg_addr[1:0]};

   // NOTE: every variable written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      all_idle = 1'b1;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         if (ch_state[i] != CH_IDLE) all_idle = 1'b0;
      end
      rd_mux = '0;
      if (sel_ctrl) rd_mux = ctrl_val;
      if (sel_gie)  rd_mux = {31'd0, gie};
      if (sel_ier)  rd_mux = {30'd0, ier};
      if (sel_isr)  rd_mux = {30'd0, isr};
      if (sel_mask) rd_mux = 32'(chan_mask);
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         req_seen          <= 1'b0;
         reg_bus.reg_ack   <= 1'b0;
         reg_bus.reg_rdata <= '0;
         running           <= 1'b0;
         ap_done           <= 1'b0;
         ap_ready          <= 1'b0;
         auto_restart      <= 1'b0;
         gie               <= 1'b0;
         ier               <= '0;
         isr               <= '0;
         chan_mask         <= '1;
         interrupt         <= 1'b0;
      end else begin
         req_seen          <= reg_bus.reg_req;
         reg_bus.reg_ack   <= access & in_window;
         reg_bus.reg_rdata <= rd_en ? rd_mux : '0;

         if (launch)          running <= 1'b1;
         else if (completion) running <= 1'b0;

         // A completion in the same cycle as a CTRL read keeps the sticky bits set.
         ap_done  <= completion | (ap_done  & ~(rd_en & sel_ctrl));
         ap_ready <= completion | (ap_ready & ~(rd_en & sel_ctrl));

         if (byte0_wr && sel_ctrl) auto_restart <= reg_bus.reg_wdata[7];
         if (byte0_wr && sel_gie)  gie          <= reg_bus.reg_wdata[0];
         if (byte0_wr && sel_ier)  ier          <= reg_bus.reg_wdata[1:0];
         if (byte0_wr && sel_mask) chan_mask    <= reg_bus.reg_wdata[NUM_ACTIONS-1:0];

         isr <= (isr ^ ((byte0_wr && sel_isr) ? reg_bus.reg_wdata[1:0] : 2'b00))
              | {2{completion}};

         interrupt <= gie & |(isr & ier);
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NUM_ACTIONS; i++) ch_state[i] <= CH_IDLE;
         go_r   <= '0;
         done_a <= '0;
      end else begin
         for (int i = 0; i < NUM_ACTIONS; i++) begin
            case (ch_state[i])
               CH_IDLE: if (launch && chan_mask[i]) begin
                  ch_state[i] <= CH_GO_REQ;
                  go_r[i]     <= 1'b1;
               end
               CH_GO_REQ: if (go_a[i]) begin
                  ch_state[i] <= CH_GO_REL;
                  go_r[i]     <= 1'b0;
               end
               CH_GO_REL: if (!go_a[i]) ch_state[i] <= CH_RUN;
               CH_RUN: if (done_r[i]) begin
                  ch_state[i] <= CH_DONE_ACK;
                  done_a[i]   <= 1'b1;
               end
               CH_DONE_ACK: if (!done_r[i]) begin
                  ch_state[i] <= CH_IDLE;
                  done_a[i]   <= 1'b0;
               end
               default: begin
                  ch_state[i] <= CH_IDLE;
                  go_r[i]     <= 1'b0;
                  done_a[i]   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
